// File: rtl/serial_cla_pkg.sv
// Shared definitions for the serial carry-look-ahead adder: slice width,
// FSM state encoding and the slice-count helper.
package serial_cla_pkg;

   // Width of one slice handled by the 4-bit CLA stage each cycle.
   localparam int SLICE_W = 4;

   // Controller states: waiting for operands, stepping slices, holding result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of 4-bit slices needed to cover a WIDTH-bit operand.
   function automatic int slice_count(input int width);
      return width / SLICE_W;
   endfunction

endpackage

// File: rtl/carry_look_ahead_adder.sv
// 4-bit carry-look-ahead adder stage. All internal carries come from
// generate/propagate terms, so there is no ripple path between bits.
module carry_look_ahead_adder (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       CarryIn,
   output logic [3:0] SumOut,
   output logic       CarryOut
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   // Generate/propagate terms and the flattened look-ahead carry equations.
   always_comb begin
      g    = A & B;
      p    = A ^ B;
      c[0] = CarryIn;
      c[1] = g[0] | (p[0] & CarryIn);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & CarryIn);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & CarryIn);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & CarryIn);
      SumOut   = p ^ c[3:0];
      CarryOut = c[4];
   end

endmodule

// File: rtl/serial_cla_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit CLA slice per clock, linked by a
// registered carry, so a WIDTH-bit add takes WIDTH/4 cycles.
// Optional signed-overflow output is built when SERIAL_CLA_OVERFLOW_EN is
// defined; without it the Overflow port and its logic are absent.
//
// Handshakes: a transfer happens on a rising Clock edge where valid and ready
// are both 1. StartReady is 1 only in IDLE and does not depend on StartValid;
// ResultValid is 1 only in DONE and stays high, with SumOut/CarryOut stable,
// until the edge where ResultReady is seen. A producer may not withdraw data
// from the outputs before that edge.
module serial_cla_adder
   import serial_cla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             Clock,
   input  logic             ResetN,
   input  logic             StartValid,
   output logic             StartReady,
   input  logic [WIDTH-1:0] OperandA,
   input  logic [WIDTH-1:0] OperandB,
   input  logic             CarryIn,
   output logic [WIDTH-1:0] SumOut,
   output logic             CarryOut,
   output logic             ResultValid,
   input  logic             ResultReady,
`ifdef SERIAL_CLA_OVERFLOW_EN
   output logic             Overflow,
`endif
   output state_t           debug_state
);

   localparam int SLICES = slice_count(WIDTH);
   localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

   // Reject widths the slice datapath cannot cover exactly.
   if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
      $error("serial_cla_adder: WIDTH must be a multiple of 4 and at least 4");
   end

   state_t             state_q;
   state_t             next_state;
   logic [IDX_W-1:0]   idx_q;
   logic               carry_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   sum_q;
   logic               cout_q;
   logic               last_slice;
   logic [SLICE_W-1:0] a_slice;
   logic [SLICE_W-1:0] b_slice;
   logic [SLICE_W-1:0] cla_sum;
   logic               cla_cout;

   // Select the slice currently being added from the captured operands.
   always_comb begin
      a_slice    = a_q[int'(idx_q) * SLICE_W +: SLICE_W];
      b_slice    = b_q[int'(idx_q) * SLICE_W +: SLICE_W];
      last_slice = (idx_q == LAST_IDX);
   end

   carry_look_ahead_adder u_cla (
      .A        (a_slice),
      .B        (b_slice),
      .CarryIn  (carry_q),
      .SumOut   (cla_sum),
      .CarryOut (cla_cout)
   );

   // State register.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q <= IDLE;
      end else begin
         state_q <= next_state;
      end
   end

   // Next-state logic: accept in IDLE, step slices in RUN, wait for consumer in DONE.
   always_comb begin
      next_state = state_q;
      unique case (state_q)
         IDLE: if (StartValid) next_state = RUN;
         RUN:  if (last_slice) next_state = DONE;
         DONE: if (ResultReady) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Handshake outputs decoded from the registered state.
   always_comb begin
      StartReady  = (state_q == IDLE);
      ResultValid = (state_q == DONE);
      debug_state = state_q;
   end

   // Operand capture on accept, then one slice written per RUN cycle; bits of
   // SumOut not yet reached keep the previous result.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (StartValid) begin
                  a_q     <= OperandA;
                  b_q     <= OperandB;
                  carry_q <= CarryIn;
                  idx_q   <= '0;
               end
            end
            RUN: begin
               sum_q[int'(idx_q) * SLICE_W +: SLICE_W] <= cla_sum;
               carry_q <= cla_cout;
               if (last_slice) begin
                  cout_q <= cla_cout;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SERIAL_CLA_OVERFLOW_EN
   logic ovf_q;

   // Signed overflow: carry into the MSB (recovered from the top slice) XOR carry out.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         ovf_q <= 1'b0;
      end else if (state_q == RUN && last_slice) begin
         ovf_q <= (cla_sum[SLICE_W-1] ^ a_slice[SLICE_W-1] ^ b_slice[SLICE_W-1]) ^ cla_cout;
      end
   end

   assign Overflow = ovf_q;
`endif

   assign SumOut   = sum_q;
   assign CarryOut = cout_q;

endmodule
